key_event_queue: RTL and testbench

Downstream consumer of the per-key debounced press pulses (one-cycle, active-high, one bit per key). Serializes simultaneous presses into a stream of encoded key events, tags a repeat press of the same key within a time window as a double-click, and buffers events in a small FIFO behind a valid/ready interface for the control logic or CPU-facing register block.

---
 rtl/key_evt_pkg.sv | 30 +++
 rtl/key_evt_fifo.sv | 63 ++++++
 rtl/key_event_queue.sv | 113 +++++++++++
 tb/tb_key_event_queue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared widths, defaults and helpers for the key event queue.
package key_evt_pkg;

  // Default sizing: four keys, four-entry queue, 250 ms at 50 MHz.
  localparam int unsigned N_DEF       = 4;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned DBL_WIN_DEF = 12500000;

  // Key code width; a single key still gets a one-bit code.
  function automatic int unsigned cw_f(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Window counter width; wide enough to hold DBL_WIN itself.
  function automatic int unsigned tw_f(input int unsigned win);
    return $clog2(win + 1);
  endfunction

  // FIFO pointer width.
  function automatic int unsigned aw_f(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // The window counter resets saturated ("window expired"), so the first
  // press after reset can never be taken for the second half of a double.
  function automatic int unsigned win_rst_f(input int unsigned win);
    return win;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous show-ahead FIFO with exact occupancy count.
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter  int unsigned W     = 3,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = aw_f(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Full/empty come straight from the registered count.
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head is forced to zero while empty so stale storage never shows.
  assign dout = empty ? '0 : mem[rd_ptr];

  // Storage write.
  // NOTE: the storage array has no reset; validity is carried by count, so
  // resetting it would only add logic.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  // NOTE: all state uses non-blocking assignment so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Serializes debounced key presses into encoded events, tags double-clicks
// and buffers them behind a valid/ready interface.
module key_event_queue
  import key_evt_pkg::*;
#(
  parameter  int unsigned N       = N_DEF,
  parameter  int unsigned DEPTH   = DEPTH_DEF,
  parameter  int unsigned DBL_WIN = DBL_WIN_DEF,
  localparam int unsigned CW      = cw_f(N),
  localparam int unsigned AW      = aw_f(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  key_pulse,
  input  logic          ev_ready,
  input  logic          ovf_clr,
  output logic          ev_valid,
  output logic [CW-1:0] ev_code,
  output logic          ev_double,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam int unsigned TW      = tw_f(DBL_WIN);
  localparam logic [TW-1:0] WIN_MAX = TW'(win_rst_f(DBL_WIN));

  typedef struct packed {
    logic          dbl;
    logic [CW-1:0] code;
  } key_evt_t;

  logic [N-1:0]  pending;
  logic [N-1:0]  grant_vec;
  logic [CW-1:0] grant_idx;
  logic          grant;
  logic          push_dbl;
  logic          lost;
  logic          last_valid;
  logic [CW-1:0] last_code;
  logic [TW-1:0] win_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  key_evt_t      push_evt;
  key_evt_t      head_evt;

  // Lowest-index pending key wins; nothing is granted while the queue is full.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_idx = '0;
    grant_vec = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (pending[i]) grant_idx = CW'(i);
    end
    grant = (|pending) && !fifo_full;
    if (grant) grant_vec[grant_idx] = 1'b1;
  end

  // A repeat of the same key inside the window (grant to grant) is a double.
  assign push_dbl = last_valid && (last_code == grant_idx) && (win_cnt < WIN_MAX);

  // A pulse on a key already waiting and not leaving this cycle is lost.
  assign lost = |(key_pulse & pending & ~grant_vec);

  assign push_evt = '{dbl: push_dbl, code: grant_idx};

  // Pending mask: drop the granted key, merge in new pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= (pending & ~grant_vec) | key_pulse;
  end

  // Window tracker: restart on every grant; a double consumes the pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_valid <= 1'b0;
      last_code  <= '0;
      win_cnt    <= WIN_MAX;
    end else if (grant) begin
      last_valid <= !push_dbl;
      last_code  <= grant_idx;
      win_cnt    <= '0;
    end else if (win_cnt != WIN_MAX) begin
      win_cnt <= win_cnt + TW'(1);
    end
  end

  // Sticky overflow; a loss in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         overflow <= 1'b0;
    else if (lost)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  key_evt_fifo #(
    .W     (CW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .din   (push_evt),
    .pop   (ev_valid && ev_ready),
    .dout  (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign ev_valid  = !fifo_empty;
  assign ev_code   = head_evt.code;
  assign ev_double = head_evt.dbl;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed self-checking bench for key_event_queue (N=4, DEPTH=4, DBL_WIN=100).
module tb_key_event_queue;

  localparam int N       = 4;
  localparam int DEPTH   = 4;
  localparam int DBL_WIN = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_pulse = '0;
  logic       ev_ready  = 1'b0;
  logic       ovf_clr   = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic       ev_double;
  logic [2:0] count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_event_queue #(
    .N       (N),
    .DEPTH   (DEPTH),
    .DBL_WIN (DBL_WIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_pulse (key_pulse),
    .ev_ready  (ev_ready),
    .ovf_clr   (ovf_clr),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_double (ev_double),
    .count     (count),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    key_pulse = '0;
    ev_ready  = 1'b0;
    ovf_clr   = 1'b0;
    rst       = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Pulse key k at one edge; return just after the grant edge.
  task automatic press(input int k);
    key_pulse = 4'(1 << k);
    tick();
    key_pulse = '0;
    tick();
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset mid-stream ----------------
    do_reset();
    check("rst_init_valid", int'(ev_valid), 0);
    check("rst_init_win", int'(dut.win_cnt), DBL_WIN);
    key_pulse = 4'b0111;
    tick();
    key_pulse = '0;
    idle(3);
    check("pre_rst_count", int'(count), 3);
    key_pulse = 4'b1000;
    tick();
    key_pulse = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_valid", int'(ev_valid), 0);
    check("rst_code", int'(ev_code), 0);
    check("rst_double", int'(ev_double), 0);
    check("rst_count", int'(count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_pending", int'(dut.pending), 0);
    check("rst_win", int'(dut.win_cnt), DBL_WIN);
    check("rst_last_valid", int'(dut.last_valid), 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_valid", int'(ev_valid), 0);
    end

    // ---------------- single press, 2-edge latency ----------------
    do_reset();
    ev_ready  = 1'b1;
    key_pulse = 4'b0100;
    tick();
    key_pulse = '0;
    check("single_k_valid", int'(ev_valid), 0);
    tick();
    check("single_k1_valid", int'(ev_valid), 1);
    check("single_code", int'(ev_code), 2);
    check("single_double", int'(ev_double), 0);
    check("single_count1", int'(count), 1);
    tick();
    check("single_k2_valid", int'(ev_valid), 0);
    check("single_count0", int'(count), 0);

    // ---------------- simultaneous presses 1011 ----------------
    do_reset();
    ev_ready  = 1'b1;
    key_pulse = 4'b1011;
    tick();
    key_pulse = '0;
    tick();
    check("multi_v0", int'(ev_valid), 1);
    check("multi_c0", int'(ev_code), 0);
    tick();
    check("multi_c1", int'(ev_code), 1);
    check("multi_cnt1", int'(count), 1);
    tick();
    check("multi_c3", int'(ev_code), 3);
    tick();
    check("multi_empty", int'(ev_valid), 0);
    check("multi_ovf", int'(overflow), 0);

    // ---------------- double-click window ----------------
    do_reset();
    ev_ready = 1'b1;
    press(1);
    check("dbl_a_valid", int'(ev_valid), 1);
    check("dbl_a", int'(ev_double), 0);
    idle(48);
    press(1);                 // 50 cycles after previous
    check("dbl_b", int'(ev_double), 1);
    idle(48);
    press(1);                 // third press is single
    check("dbl_c", int'(ev_double), 0);
    idle(98);
    press(1);                 // exactly DBL_WIN cycles apart
    check("dbl_edge100", int'(ev_double), 1);
    idle(48);
    press(1);
    check("dbl_after_pair", int'(ev_double), 0);
    idle(99);
    press(1);                 // DBL_WIN+1 cycles apart
    check("dbl_late101", int'(ev_double), 0);
    idle(8);
    press(2);                 // other key inside window
    check("dbl_other_key", int'(ev_double), 0);
    check("dbl_other_code", int'(ev_code), 2);
    idle(8);
    press(2);
    check("dbl_key2", int'(ev_double), 1);

    // ---------------- full queue, stall, overflow ----------------
    do_reset();
    ev_ready  = 1'b0;
    key_pulse = 4'b1111;
    tick();
    key_pulse = '0;
    idle(4);
    check("full_count", int'(count), 4);
    check("full_head", int'(ev_code), 0);
    key_pulse = 4'b0001;
    tick();
    key_pulse = '0;
    check("stall_ovf", int'(overflow), 0);
    idle(2);
    check("stall_pending", int'(dut.pending), 1);
    check("stall_count", int'(count), 4);
    key_pulse = 4'b0001;
    tick();
    key_pulse = '0;
    check("lost_ovf", int'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_ovf", int'(overflow), 0);
    key_pulse = 4'b0001;
    ovf_clr   = 1'b1;
    tick();
    key_pulse = '0;
    ovf_clr   = 1'b0;
    check("set_wins_ovf", int'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr2_ovf", int'(overflow), 0);
    ev_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("drain_valid", int'(ev_valid), 1);
      check("drain_code", int'(ev_code), i % 4);
      check("drain_double", int'(ev_double), 0);
      tick();
    end
    check("drain_empty", int'(ev_valid), 0);
    check("drain_count", int'(count), 0);
    check("drain_ovf", int'(overflow), 0);

    // ---------------- push+pop at DEPTH-1, pointer wrap ----------------
    do_reset();
    for (int c = 1; c <= 19; c++) begin
      int exp_cnt;
      if (c == 1)                 key_pulse = 4'b0111;
      else if (c >= 4 && c <= 15) key_pulse = 4'(1 << ((c - 1) % 4));
      else                        key_pulse = '0;
      ev_ready = (c >= 5);
      if (c >= 5) begin
        check("wrap_valid", int'(ev_valid), 1);
        check("wrap_code", int'(ev_code), (c - 5) % 4);
        check("wrap_double", int'(ev_double), 0);
      end
      tick();
      if (c <= 4)       exp_cnt = c - 1;
      else if (c <= 16) exp_cnt = 3;
      else              exp_cnt = 19 - c;
      check("wrap_count", int'(count), exp_cnt);
    end
    key_pulse = '0;
    check("wrap_empty", int'(ev_valid), 0);
    check("wrap_ovf", int'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
